// File: rtl/keycode_fifo_pkg.sv
// Shared keyboard-path types and defaults for the keycode capture buffer.
package kbd_pkg;

  localparam int KEY_W         = 8;
  localparam int DEFAULT_DEPTH = 8;

  typedef logic [KEY_W-1:0] keycode_t;

endpackage

// File: rtl/keycode_fifo_if.sv
// Bus between the scan/decoder + consumer side (master) and the capture FIFO (slave).
interface keycode_fifo_if
  import kbd_pkg::*;
#(
  parameter int DATA_W = KEY_W,
  parameter int DEPTH  = DEFAULT_DEPTH
);

  localparam int CW = $clog2(DEPTH + 1);

  logic              strobe;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic              clr_ovf;
  logic [DATA_W-1:0] dout;
  logic              valid;
  logic              full;
  logic [CW-1:0]     count;
  logic              overflow;
  logic [DATA_W-1:0] last_byte;

  modport master (
    output strobe, din, rd_en, clr_ovf,
    input  dout, valid, full, count, overflow, last_byte
  );

  modport slave (
    input  strobe, din, rd_en, clr_ovf,
    output dout, valid, full, count, overflow, last_byte
  );

endinterface

// File: rtl/keycode_fifo_strobe_edge.sv
// Turns the decoder strobe into a one-cycle capture pulse (edge mode) or passes it through (level mode).
module strobe_edge #(
  parameter int EDGE_MODE = 1
) (
  input  logic clk,
  input  logic nrst,
  input  logic strobe_i,
  output logic cap_o
);

  if (EDGE_MODE != 0) begin : g_edge
    logic strobe_q;

    // Previous strobe level; reset to 0 so a strobe already high at release counts as an edge.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) strobe_q <= 1'b0;
      else       strobe_q <= strobe_i;
    end

    assign cap_o = strobe_i & ~strobe_q;
  end else begin : g_level
    assign cap_o = strobe_i;
  end

endmodule

// File: rtl/keycode_fifo.sv
// Keycode capture FIFO: show-ahead head, occupancy status, sticky overflow and last-captured copy.
module keycode_fifo
  import kbd_pkg::*;
#(
  parameter int DATA_W    = KEY_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int EDGE_MODE = 1
) (
  input logic           clk,
  input logic           nrst,
  keycode_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] last_q, last_d;

  logic cap;
  logic is_full;
  logic not_empty;
  logic do_rd;
  logic do_wr;
  logic drop;

  strobe_edge #(
    .EDGE_MODE(EDGE_MODE)
  ) u_strobe_edge (
    .clk     (clk),
    .nrst    (nrst),
    .strobe_i(bus.strobe),
    .cap_o   (cap)
  );

  assign is_full   = (count_q == FULL_CNT);
  assign not_empty = (count_q != '0);
  assign do_rd     = bus.rd_en & not_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the new word.
  assign do_wr     = cap & (~is_full | do_rd);
  assign drop      = cap & is_full & ~do_rd;

  // Next-state for pointers, occupancy, overflow and last-captured word.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    last_d  = last_q;
    if (do_wr) wptr_d = wptr_q + AW'(1);
    if (do_rd) rptr_d = rptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (cap) last_d = bus.din;
    if (drop)             ovf_d = 1'b1;
    else if (bus.clr_ovf) ovf_d = 1'b0;
  end

  // Pointer/count/flag registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
    end
  end

  // Storage array; left unreset since empty entries are masked at the output.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= bus.din;
  end

  // Show-ahead head entry, forced to zero while empty.
  always_comb begin
    bus.dout = '0;
    if (not_empty) bus.dout = mem_q[rptr_q];
  end

  assign bus.valid     = not_empty;
  assign bus.full      = is_full;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.last_byte = last_q;

endmodule

// File: tb/tb_keycode_fifo.sv
// Bench for keycode_fifo: one edge-mode and one level-mode instance, directed sequences,
// a vector table on the level instance, and randomized traffic against a queue model.
module tb_keycode_fifo;
  import kbd_pkg::*;

  localparam int D = 8;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  keycode_fifo_if #(.DATA_W(KEY_W), .DEPTH(D)) ife ();
  keycode_fifo_if #(.DATA_W(KEY_W), .DEPTH(D)) ifl ();

  keycode_fifo #(.DATA_W(KEY_W), .DEPTH(D), .EDGE_MODE(1)) dut_e (
    .clk (clk),
    .nrst(nrst),
    .bus (ife.slave)
  );

  keycode_fifo #(.DATA_W(KEY_W), .DEPTH(D), .EDGE_MODE(0)) dut_l (
    .clk (clk),
    .nrst(nrst),
    .bus (ifl.slave)
  );

  typedef struct {
    logic     stb;
    keycode_t din;
    logic     rd;
    logic     clr;
    int       cnt;
    int       dout;
    int       ovf;
    int       last;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: index 0 = edge-mode instance, 1 = level-mode instance.
  keycode_t mq0[$];
  keycode_t mq1[$];
  logic     mprev [2];
  int       movf  [2];
  int       mlast [2];

  task automatic add(input logic s, input int d, input logic r, input logic c,
                     input int cnt, input int dout, input int ovf, input int last);
    vec_t v;
    v.stb = s; v.din = 8'(d); v.rd = r; v.clr = c;
    v.cnt = cnt; v.dout = dout; v.ovf = ovf; v.last = last;
    tbl.push_back(v);
  endtask

  task automatic set_in(input int m, input logic s, input int d, input logic r, input logic c);
    if (m == 0) begin
      ife.strobe = s; ife.din = 8'(d); ife.rd_en = r; ife.clr_ovf = c;
    end else begin
      ifl.strobe = s; ifl.din = 8'(d); ifl.rd_en = r; ifl.clr_ovf = c;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input int m, input string tag, input int cnt, input int dout,
                         input int ovf, input int last);
    int a_cnt, a_dout, a_valid, a_full, a_ovf, a_last;
    if (m == 0) begin
      a_cnt = int'(ife.count); a_dout = int'(ife.dout); a_valid = int'(ife.valid);
      a_full = int'(ife.full); a_ovf = int'(ife.overflow); a_last = int'(ife.last_byte);
    end else begin
      a_cnt = int'(ifl.count); a_dout = int'(ifl.dout); a_valid = int'(ifl.valid);
      a_full = int'(ifl.full); a_ovf = int'(ifl.overflow); a_last = int'(ifl.last_byte);
    end
    chk1($sformatf("%s/m%0d/count", tag, m), a_cnt, cnt);
    chk1($sformatf("%s/m%0d/dout", tag, m), a_dout, dout);
    chk1($sformatf("%s/m%0d/valid", tag, m), a_valid, (cnt > 0) ? 1 : 0);
    chk1($sformatf("%s/m%0d/full", tag, m), a_full, (cnt == D) ? 1 : 0);
    chk1($sformatf("%s/m%0d/overflow", tag, m), a_ovf, ovf);
    chk1($sformatf("%s/m%0d/last_byte", tag, m), a_last, last);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    step();
    nrst = 1'b1;
  endtask

  task automatic model_reset();
    mq0.delete(); mq1.delete();
    for (int i = 0; i < 2; i++) begin
      mprev[i] = 1'b0; movf[i] = 0; mlast[i] = 0;
    end
  endtask

  // One clock of the FIFO rules: pop (if anything to pop), then accept/drop the capture.
  task automatic model_cycle(input int m, input logic s, input int d, input logic r, input logic c);
    int   sz;
    logic ev, rd, drop;
    sz = (m == 0) ? mq0.size() : mq1.size();
    ev = (m == 0) ? (s && !mprev[0]) : s;
    mprev[m] = s;
    rd = r && (sz > 0);
    drop = ev && (sz == D) && !rd;
    if (rd) begin
      if (m == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
    end
    if (ev && !drop) begin
      if (m == 0) mq0.push_back(8'(d)); else mq1.push_back(8'(d));
    end
    if (ev) mlast[m] = d;
    if (drop) movf[m] = 1;
    else if (c) movf[m] = 0;
  endtask

  task automatic model_check(input int m, input string tag);
    int sz, head;
    sz   = (m == 0) ? mq0.size() : mq1.size();
    head = 0;
    if (sz > 0) head = (m == 0) ? int'(mq0[0]) : int'(mq1[0]);
    chk_all(m, tag, sz, head, movf[m], mlast[m]);
  endtask

  initial begin
    int drain [8];
    set_in(0, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 0);

    // Power-on reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_all(0, "reset", 0, 0, 0, 0);
    chk_all(1, "reset", 0, 0, 0, 0);
    nrst = 1'b1;

    // Fill edge instance partly, then reset asynchronously between clock edges.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 8'h10 + i, 0, 0); step();
      set_in(0, 0, 0, 0, 0);         step();
    end
    chk_all(0, "prefill", 3, 8'h10, 0, 8'h12);
    #2;
    nrst = 1'b0;
    #1;
    chk_all(0, "async_rst", 0, 0, 0, 0);
    step();
    nrst = 1'b1;
    set_in(0, 1, 8'h1C, 0, 0); step();
    chk_all(0, "after_rst", 1, 8'h1C, 0, 8'h1C);
    set_in(0, 0, 0, 0, 0); step();

    // Strobe held five cycles: one capture in edge mode, five in level mode.
    do_reset();
    set_in(0, 1, 8'h23, 0, 0);
    set_in(1, 1, 8'h23, 0, 0);
    repeat (5) step();
    set_in(0, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 0);
    step();
    chk_all(0, "held", 1, 8'h23, 0, 8'h23);
    chk_all(1, "held", 5, 8'h23, 0, 8'h23);

    // Strobe already high when reset releases counts as an edge.
    nrst = 1'b0;
    set_in(0, 1, 8'h77, 0, 0);
    step();
    nrst = 1'b1;
    step();
    chk_all(0, "rel_edge", 1, 8'h77, 0, 8'h77);
    step();
    chk_all(0, "rel_hold", 1, 8'h77, 0, 8'h77);
    set_in(0, 0, 0, 0, 0);

    // Vector table on the level instance: fill, overflow, clear priority, swap-at-full, drain.
    for (int i = 1; i <= 8; i++) add(1, i, 0, 0, i, 8'h01, 0, i);
    add(1, 8'h09, 0, 0, 8, 8'h01, 1, 8'h09);
    add(1, 8'h0A, 0, 1, 8, 8'h01, 1, 8'h0A);
    add(0, 8'h00, 0, 1, 8, 8'h01, 0, 8'h0A);
    add(1, 8'hAA, 1, 0, 8, 8'h02, 0, 8'hAA);
    drain = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA, 8'h00};
    for (int k = 0; k < 8; k++) add(0, 0, 1, 0, 7 - k, drain[k], 0, 8'hAA);
    add(0, 0, 1, 0, 0, 0, 0, 8'hAA);
    add(1, 8'h5A, 1, 0, 1, 8'h5A, 0, 8'h5A);
    add(0, 0, 1, 0, 0, 0, 0, 8'h5A);

    do_reset();
    foreach (tbl[i]) begin
      set_in(1, tbl[i].stb, int'(tbl[i].din), tbl[i].rd, tbl[i].clr);
      step();
      chk_all(1, $sformatf("vec%0d", i), tbl[i].cnt, tbl[i].dout, tbl[i].ovf, tbl[i].last);
    end
    set_in(1, 0, 0, 0, 0);

    // Randomized traffic on both instances against the queue model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic s, r, c;
      int   d;
      int   rd_pct;
      rd_pct = (cyc < 200) ? 15 : ((cyc < 400) ? 70 : 45);
      s = ($urandom_range(99) < 55);
      r = ($urandom_range(99) < rd_pct);
      c = ($urandom_range(99) < 6);
      d = int'($urandom_range(255));
      set_in(0, s, d, r, c);
      set_in(1, s, d, r, c);
      model_cycle(0, s, d, r, c);
      model_cycle(1, s, d, r, c);
      step();
      model_check(0, $sformatf("rnd%0d", cyc));
      model_check(1, $sformatf("rnd%0d", cyc));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
